// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, latency.
// Signed operation support in muldiv_unit is enabled by defining MULDIV_SIGNED_EN.
package muldiv_pkg;

   localparam int WIDTH_DEFAULT = 32;
   localparam int MULDIV_LAT    = WIDTH_DEFAULT + 1;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN
   } state_e;

   // Start-to-done latency for an arbitrary operand width.
   function automatic int muldiv_lat(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Purely combinational; the partial result lives in {p_hi, p_lo}.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] p_hi,
   input  logic [WIDTH-1:0] p_lo,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] n_hi,
   output logic [WIDTH-1:0] n_lo
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
   always_comb begin
      sum     = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : '0);
      shifted = {p_hi, p_lo[WIDTH-1]};
      trial   = shifted - {1'b0, m};
      n_hi    = sum[WIDTH:1];
      n_lo    = {sum[0], p_lo[WIDTH-1:1]};
      if (is_div) begin
         // A borrow out of the trial subtraction means the divisor did not fit: restore.
         if (trial[WIDTH]) begin
            n_hi = shifted[WIDTH-1:0];
            n_lo = {p_lo[WIDTH-2:0], 1'b0};
         end else begin
            n_hi = trial[WIDTH-1:0];
            n_lo = {p_lo[WIDTH-2:0], 1'b1};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit with a fixed WIDTH+1 cycle latency.
// Define MULDIV_SIGNED_EN to execute MULT/DIV as signed; otherwise every op is unsigned.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             is_div;
   logic             zero_div;
   logic [WIDTH-1:0] p_hi, p_lo, m;
   logic [WIDTH-1:0] n_hi, n_lo;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic             b_is_zero;

   assign busy      = (state != S_IDLE);
   assign b_is_zero = (b == '0);

`ifdef MULDIV_SIGNED_EN
   logic             a_neg, b_neg;
   logic             neg_lo, neg_hi;
   logic [2*WIDTH-1:0] prod;

   assign a_neg = ~op[0] & a[WIDTH-1];
   assign b_neg = ~op[0] & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // neg_lo: product or quotient is negative; neg_hi: remainder follows the dividend.
   assign prod = neg_lo ? -{p_hi, p_lo} : {p_hi, p_lo};
   always_comb begin
      if (is_div) begin
         res_hi = neg_hi ? -p_hi : p_hi;
         res_lo = neg_lo ? -p_lo : p_lo;
      end else begin
         {res_hi, res_lo} = prod;
      end
   end
`else
   logic unused_op0;

   assign unused_op0 = op[0];
   assign a_mag      = a;
   assign b_mag      = b;
   assign res_hi     = p_hi;
   assign res_lo     = p_lo;
`endif

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (is_div),
      .p_hi   (p_hi),
      .p_lo   (p_lo),
      .m      (m),
      .n_hi   (n_hi),
      .n_lo   (n_lo)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         is_div   <= 1'b0;
         zero_div <= 1'b0;
         p_hi     <= '0;
         p_lo     <= '0;
         m        <= '0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
`endif
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         if (flush && state != S_IDLE) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (wr_hi) hi <= wdata;
                  if (wr_lo) lo <= wdata;
                  // A squash in the same cycle drops the request.
                  if (start && !flush) begin
                     is_div   <= op[1];
                     zero_div <= op[1] & b_is_zero;
                     cnt      <= CNT_W'(WIDTH);
                     p_hi     <= '0;
                     p_lo     <= op[1] ? a_mag : b_mag;
                     m        <= op[1] ? b_mag : a_mag;
                     state    <= (op[1] && b_is_zero) ? S_FIN : S_RUN;
`ifdef MULDIV_SIGNED_EN
                     neg_lo   <= a_neg ^ b_neg;
                     neg_hi   <= a_neg;
`endif
                  end
               end
               S_RUN: begin
                  p_hi <= n_hi;
                  p_lo <= n_lo;
                  cnt  <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) state <= S_FIN;
               end
               S_FIN: begin
                  done     <= 1'b1;
                  div_zero <= zero_div;
                  if (!zero_div) begin
                     hi <= res_hi;
                     lo <= res_lo;
                  end
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, meaning operand and HI/LO width (8..64, even).
REQ-002 The block SHALL take parameter CNT_W, default $clog2(WIDTH+1), meaning iteration-counter width.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, request to begin an operation.
REQ-006 The block SHALL have port op, input, 2, operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 The block SHALL have port a, input, WIDTH, the rs operand (multiplicand or dividend).
REQ-008 The block SHALL have port b, input, WIDTH, the rt operand (multiplier or divisor).
REQ-009 The block SHALL have port flush, input, 1, pipeline squash that cancels an in-flight operation.
REQ-010 The block SHALL have ports wr_hi and wr_lo, input, 1 each, MTHI/MTLO strobes that write wdata.
REQ-011 The block SHALL have port wdata, input, WIDTH, the MTHI/MTLO data.
REQ-012 The block SHALL have ports busy and done, output, 1 each: busy = operation in progress; done = one-cycle completion pulse.
REQ-013 The block SHALL have port div_zero, output, 1, asserted together with done when a divide has b == 0.
REQ-014 The block SHALL have ports hi and lo, output, WIDTH each, the architectural HI/LO registers, for MFHI/MFLO.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and FIN; busy SHALL be 1 in RUN and FIN only.
REQ-016 start SHALL be sampled only in IDLE; start in RUN or FIN SHALL be ignored, with no queuing.
REQ-017 On an accepted start the block SHALL latch op, a and b, load the counter with WIDTH, and go to RUN.
REQ-018 RUN SHALL perform one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide), decrement the counter, and go to FIN after the step where the counter reaches 0.
REQ-019 FIN SHALL write hi and lo, pulse done for one cycle, and return to IDLE.
REQ-020 Latency SHALL be fixed: the start edge in cycle 0 gives done in cycle WIDTH+1, and the block SHALL accept a new start in cycle WIDTH+2.
REQ-021 Multiply SHALL produce a 2*WIDTH product: hi gets the upper half, lo the lower half.
REQ-022 Divide SHALL write the quotient to lo and the remainder to hi.
REQ-023 Signed divide SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-024 DIV of -2^(WIDTH-1) by -1 SHALL give lo = -2^(WIDTH-1) and hi = 0.
REQ-025 Divide with b == 0 SHALL skip RUN and go straight to FIN: done and div_zero assert in cycle 1, and hi and lo stay unchanged.
REQ-026 flush SHALL force IDLE on the next edge with no done pulse and hi/lo unchanged; flush in IDLE SHALL have no effect.
REQ-027 flush and start in the same IDLE cycle: start SHALL be dropped.
REQ-028 wr_hi/wr_lo SHALL take effect only in IDLE and SHALL be ignored while busy.
REQ-029 wr_hi/wr_lo together with start in the same cycle: the write SHALL take effect and the operation SHALL start, and the operation result later overwrites it.

Reset
REQ-030 Assertion of reset_n low SHALL immediately force state IDLE, busy = 0, done = 0, div_zero = 0, hi = 0 and lo = 0, including mid-operation.
REQ-031 The first start SHALL be honoured on the first rising edge after reset_n deasserts.

Configuration
REQ-032 With MULDIV_SIGNED_EN defined, MULT and DIV SHALL pre-negate negative operands to magnitudes and post-correct the signs of the results.
REQ-033 Without MULDIV_SIGNED_EN, op[0] SHALL be ignored and every operation executes as unsigned, with no sign logic synthesised.

Structure
REQ-034 The op encodings, the FSM state enum and the MULDIV_LAT = WIDTH+1 constant SHALL live in shared package muldiv_pkg.
REQ-035 One sub-module, muldiv_step, SHALL implement the purely combinational single-iteration shift/add/subtract datapath; the FSM, counter and HI/LO registers SHALL remain in muldiv_unit.

Verification
REQ-036 MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF (WIDTH=32) -> done in cycle 33 with hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 MULT with a=-3, b=7 (MULDIV_SIGNED_EN defined) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; without the macro -> hi=0x00000006, lo=0xFFFFFFEB.
REQ-038 DIV with a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with a=100, b=7 -> lo=14, hi=2.
REQ-039 DIVU with a=5, b=0 and prior hi=0x11, lo=0x22 -> done and div_zero in cycle 1, hi=0x11, lo=0x22.
REQ-040 MULTU start, then flush in cycle 10 -> busy=0 in cycle 11, no done pulse, hi/lo unchanged; a second start in cycle 12 is accepted.
REQ-041 reset_n low in cycle 5 of a DIVU -> busy, done, hi and lo all 0 immediately; start while busy, and wr_hi while busy, are both ignored.
